// File: rtl/puf_eval_sequencer_if.sv
// Request/response and PUF-facing signal bundle for puf_eval_sequencer.
interface puf_eval_sequencer_if;
    logic       ena;
    logic       start;
    logic [7:0] challenge_in;
    logic [7:0] puf_challenge;
    logic       puf_pulse;
    logic [7:0] puf_response;
    logic       busy;
    logic       done;
    logic [7:0] response_out;
    logic [7:0] unstable_mask;

    // Requester side: drives the request and models the PUF array.
    modport master (
        output ena, start, challenge_in, puf_response,
        input  puf_challenge, puf_pulse, busy, done, response_out, unstable_mask
    );

    // Sequencer side.
    modport slave (
        input  ena, start, challenge_in, puf_response,
        output puf_challenge, puf_pulse, busy, done, response_out, unstable_mask
    );
endinterface

// File: rtl/puf_eval_sequencer.sv
// Drives an 8-bit arbiter PUF through NUM_EVAL excitation pulses per request,
// majority-votes each response bit and flags bits that disagreed.
module puf_eval_sequencer #(
    parameter int unsigned NUM_EVAL      = 7,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    puf_eval_sequencer_if.slave  bus
);

    localparam int unsigned WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  EVAL_LAST = CNT_W'(NUM_EVAL - 1);
    localparam logic [CNT_W-1:0]  MAJ_HALF  = CNT_W'(NUM_EVAL / 2);
    localparam logic [CNT_W-1:0]  ALL_ONES  = CNT_W'(NUM_EVAL);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FIRE,
        SAMPLE,
        RESOLVE
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   eval_q, eval_d;
    logic [CNT_W-1:0]   ones_q [8];
    logic [CNT_W-1:0]   ones_d [8];
    logic [7:0]         chal_q, chal_d;
    logic               pulse_q, pulse_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         resp_q, resp_d;
    logic [7:0]         mask_q, mask_d;
    logic [7:0]         resp_meta, resp_sync;

    // Two-flop synchronizer for the asynchronous PUF response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_meta <= '0;
            resp_sync <= '0;
        end else begin
            resp_meta <= bus.puf_response;
            resp_sync <= resp_meta;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            eval_q  <= '0;
            ones_q  <= '{default: '0};
            chal_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            resp_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            eval_q  <= eval_d;
            ones_q  <= ones_d;
            chal_q  <= chal_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            resp_q  <= resp_d;
            mask_q  <= mask_d;
        end
    end

    // Next-state, counter and output logic; an ena drop abandons the request.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        eval_d  = eval_q;
        ones_d  = ones_q;
        chal_d  = chal_q;
        resp_d  = resp_q;
        mask_d  = mask_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && bus.ena) begin
                    chal_d  = bus.challenge_in;
                    ones_d  = '{default: '0};
                    eval_d  = '0;
                    wait_d  = '0;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = FIRE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            FIRE: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = SAMPLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            SAMPLE: begin
                for (int i = 0; i < 8; i++) begin
                    ones_d[i] = ones_q[i] + CNT_W'(resp_sync[i]);
                end
                if (eval_q == EVAL_LAST) begin
                    state_d = RESOLVE;
                end else begin
                    eval_d  = eval_q + CNT_W'(1);
                    state_d = ARM;
                end
            end
            RESOLVE: begin
                for (int i = 0; i < 8; i++) begin
                    resp_d[i] = (ones_q[i] > MAJ_HALF);
                    mask_d[i] = (ones_q[i] != '0) && (ones_q[i] != ALL_ONES);
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!bus.ena && (state_q != IDLE)) begin
            state_d = IDLE;
            wait_d  = '0;
            eval_d  = '0;
            ones_d  = '{default: '0};
            resp_d  = resp_q;
            mask_d  = mask_q;
            done_d  = 1'b0;
        end

        pulse_d = (state_d == FIRE) || (state_d == SAMPLE);
        busy_d  = (state_d != IDLE);
    end

    assign bus.puf_challenge = chal_q;
    assign bus.puf_pulse     = pulse_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.response_out  = resp_q;
    assign bus.unstable_mask = mask_q;

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Directed bench for puf_eval_sequencer with a behavioural PUF model.
module tb_puf_eval_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    puf_eval_sequencer_if pif ();

    puf_eval_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (pif)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // PUF model: mode 0 -> constant 0xA5; mode 1 -> 0x5A base, bit0 set on even
    // evaluations (4 of 7), bit7 set on odd evaluations (3 of 7). Zero when idle.
    int total_rises = 0;
    int base_rises  = 0;
    int mode        = 0;
    int idx;
    logic idx_odd;

    always @(posedge pif.puf_pulse) total_rises <= total_rises + 1;

    always_comb begin
        idx     = total_rises - base_rises - 1;
        idx_odd = idx[0];
        if (!pif.puf_pulse)
            pif.puf_response = 8'h00;
        else if (mode == 0)
            pif.puf_response = 8'hA5;
        else
            pif.puf_response = {idx_odd, 6'b101101, ~idx_odd};
    end

    // Results captured by run_req.
    int   r_done_cnt;
    int   r_done_cyc;
    int   r_rises;
    logic r_chal_ok;
    logic r_pulse2, r_pulse3, r_busy11, r_pulse11, r_busy36;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request at a posedge+1 point and observe cycles 1..45.
    task automatic run_req(input logic [7:0] chal, input int busy_at, input int abort_at);
        base_rises = total_rises;
        r_done_cnt = 0;
        r_done_cyc = -1;
        r_chal_ok  = 1'b1;
        pif.challenge_in = chal;
        pif.start = 1'b1;
        pif.ena   = 1'b1;
        @(posedge clk); #1;
        pif.start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (pif.done === 1'b1) begin
                r_done_cnt++;
                if (r_done_cyc < 0) r_done_cyc = c;
            end
            if (pif.puf_challenge !== chal) r_chal_ok = 1'b0;
            if (c == 2) r_pulse2 = pif.puf_pulse;
            if (c == 3) r_pulse3 = pif.puf_pulse;
            if (c == 11) begin
                r_busy11  = pif.busy;
                r_pulse11 = pif.puf_pulse;
            end
            if (c == 36) r_busy36 = pif.busy;
            pif.start = (c == busy_at);
            if (c == busy_at) pif.challenge_in = 8'hFF;
            pif.ena = (c != abort_at);
            @(posedge clk); #1;
        end
        r_rises   = total_rises - base_rises;
        pif.start = 1'b0;
        pif.ena   = 1'b1;
    endtask

    initial begin
        // Reset with random inputs.
        rst_n = 1'b0;
        pif.ena          = 1'($urandom);
        pif.start        = 1'($urandom);
        pif.challenge_in = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check("rst_challenge", 32'(pif.puf_challenge), 32'h0);
        check("rst_pulse",     32'(pif.puf_pulse),     32'h0);
        check("rst_busy",      32'(pif.busy),          32'h0);
        check("rst_done",      32'(pif.done),          32'h0);
        check("rst_resp",      32'(pif.response_out),  32'h0);
        check("rst_mask",      32'(pif.unstable_mask), 32'h0);
        pif.start = 1'b0;
        pif.ena   = 1'b1;
        rst_n     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy",  32'(pif.busy),      32'h0);
        check("idle_pulse", 32'(pif.puf_pulse), 32'h0);

        // Stable PUF.
        mode = 0;
        run_req(8'h3C, 0, 0);
        check("stable_chal",   32'(r_chal_ok),  32'h1);
        check("stable_pulse2", 32'(r_pulse2),   32'h0);
        check("stable_pulse3", 32'(r_pulse3),   32'h1);
        check("stable_busy36", 32'(r_busy36),   32'h1);
        check("stable_rises",  32'(r_rises),    32'd7);
        check("stable_ndone",  32'(r_done_cnt), 32'd1);
        check("stable_dcyc",   32'(r_done_cyc), 32'd37);
        check("stable_resp",   32'(pif.response_out),  32'hA5);
        check("stable_mask",   32'(pif.unstable_mask), 32'h00);

        // Noisy bits 0 and 7.
        mode = 1;
        run_req(8'h11, 0, 0);
        check("noisy_rises", 32'(r_rises),    32'd7);
        check("noisy_ndone", 32'(r_done_cnt), 32'd1);
        check("noisy_dcyc",  32'(r_done_cyc), 32'd37);
        check("noisy_resp",  32'(pif.response_out),  32'h5B);
        check("noisy_mask",  32'(pif.unstable_mask), 32'h81);

        // Start while busy is ignored.
        mode = 0;
        run_req(8'h3C, 5, 0);
        check("busy_chal",  32'(r_chal_ok),  32'h1);
        check("busy_ndone", 32'(r_done_cnt), 32'd1);
        check("busy_dcyc",  32'(r_done_cyc), 32'd37);
        check("busy_rises", 32'(r_rises),    32'd7);
        check("busy_resp",  32'(pif.response_out),  32'hA5);
        check("busy_chal_after", 32'(pif.puf_challenge), 32'h3C);

        // Abort via ena at cycle 10, then a clean request.
        mode = 1;
        run_req(8'h22, 0, 10);
        check("abort_busy11",  32'(r_busy11),   32'h0);
        check("abort_pulse11", 32'(r_pulse11),  32'h0);
        check("abort_ndone",   32'(r_done_cnt), 32'd0);
        check("abort_resp",    32'(pif.response_out),  32'hA5);
        check("abort_mask",    32'(pif.unstable_mask), 32'h00);
        run_req(8'h77, 0, 0);
        check("post_abort_dcyc",  32'(r_done_cyc), 32'd37);
        check("post_abort_rises", 32'(r_rises),    32'd7);
        check("post_abort_resp",  32'(pif.response_out),  32'h5B);
        check("post_abort_mask",  32'(pif.unstable_mask), 32'h81);

        // Asynchronous reset mid-FIRE.
        mode = 0;
        pif.challenge_in = 8'h3C;
        pif.start = 1'b1;
        @(posedge clk); #1;
        pif.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("ar_pulse_fire", 32'(pif.puf_pulse), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_pulse_drop", 32'(pif.puf_pulse), 32'h0);
        check("ar_busy",       32'(pif.busy),      32'h0);
        check("ar_done",       32'(pif.done),      32'h0);
        check("ar_resp",       32'(pif.response_out), 32'h0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ar_idle_busy", 32'(pif.busy), 32'h0);
        mode = 1;
        run_req(8'h5C, 0, 0);
        check("ar_next_rises", 32'(r_rises),    32'd7);
        check("ar_next_ndone", 32'(r_done_cnt), 32'd1);
        check("ar_next_dcyc",  32'(r_done_cyc), 32'd37);
        check("ar_next_resp",  32'(pif.response_out),  32'h5B);
        check("ar_next_mask",  32'(pif.unstable_mask), 32'h81);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
